// File: rtl/calc_zbuf_if.sv
// Signal bundle between the calc result stream and its downstream consumer.
// Handshakes: calc pushes Z with pushZ and cannot be stalled. Zo is taken on
// every rising edge where pushZo is high and stopZo is low.
interface calc_zbuf_if #(
    parameter int W     = 32,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  Z;
    logic          pushZ;
    logic [W-1:0]  Zo;
    logic          pushZo;
    logic          stopZo;
    logic [CW-1:0] count;
    logic          full;
    logic          ovf;

    modport master (
        output Z, pushZ, stopZo,
        input  Zo, pushZo, count, full, ovf
    );

    modport slave (
        input  Z, pushZ, stopZo,
        output Zo, pushZo, count, full, ovf
    );
endinterface

// File: rtl/calc_zbuf.sv
// Elastic output buffer for calc results. Every push is accepted into a FIFO;
// pushes that arrive while the FIFO is full and stalled are dropped and flagged in ovf.
module calc_zbuf #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input logic        clk,
    input logic        rst,
    calc_zbuf_if.slave zb
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          ovf_q;

    logic is_full;
    logic pop;
    logic wr;
    logic drop;

    assign is_full = (cnt == CW'(DEPTH));
    assign pop     = (cnt != '0) && !zb.stopZo;
    // A pop frees the head slot on the same edge, so a full FIFO can still accept.
    assign wr      = zb.pushZ && (!is_full || pop);
    assign drop    = zb.pushZ && is_full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (wr)
                wp <= wp + AW'(1);
            if (pop)
                rp <= rp + AW'(1);
            if (wr && !pop)
                cnt <= cnt + CW'(1);
            else if (pop && !wr)
                cnt <= cnt - CW'(1);
            if (drop)
                ovf_q <= 1'b1;
        end
    end

    // Storage is deliberately not reset; Zo is meaningless while pushZo is low.
    always_ff @(posedge clk) begin
        if (wr)
            mem[wp] <= zb.Z;
    end

    assign zb.Zo     = mem[rp];
    assign zb.pushZo = (cnt != '0);
    assign zb.count  = cnt;
    assign zb.full   = is_full;
    assign zb.ovf    = ovf_q;
endmodule

// File: tb/tb_calc_zbuf.sv
// Directed and random stimulus for calc_zbuf, checked against a queue model
// every cycle plus literal expectations for the hand-worked scenarios.
module tb_calc_zbuf;
  localparam int W     = 32;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;

  calc_zbuf_if #(.W(W), .DEPTH(DEPTH)) zb ();

  calc_zbuf #(.W(W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .zb  (zb.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  logic [W-1:0] model_q[$];
  logic         m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: FIFO of accepted values, sticky drop flag
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_q.delete();
      m_ovf <= 1'b0;
    end else begin
      if (model_q.size() != 0 && !zb.stopZo)
        void'(model_q.pop_front());
      if (zb.pushZ) begin
        if (model_q.size() == DEPTH)
          m_ovf <= 1'b1;
        else
          model_q.push_back(zb.Z);
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("pushZo", 32'(zb.pushZo), 32'(model_q.size() != 0));
      check("count", 32'(zb.count), 32'(model_q.size()));
      check("full", 32'(zb.full), 32'(model_q.size() == DEPTH));
      check("ovf", 32'(zb.ovf), 32'(m_ovf));
      if (model_q.size() != 0)
        check("Zo", zb.Zo, model_q[0]);
    end
  end

  // driver tasks
  task automatic cycle(input logic push, input logic [W-1:0] z, input logic stop);
    @(negedge clk);
    zb.pushZ  = push;
    zb.Z      = z;
    zb.stopZo = stop;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    zb.pushZ = 1'b0;
    zb.stopZo = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    zb.pushZ  = 1'b0;
    zb.Z      = '0;
    zb.stopZo = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pushZo", 32'(zb.pushZo), 32'd0);
    check("rst_count", 32'(zb.count), 32'd0);
    check("rst_ovf", 32'(zb.ovf), 32'd0);
    rst = 1'b1;
    cmp_en = 1'b1;

    // async reset with 3 entries held
    cycle(1'b1, 32'h1, 1'b1);
    cycle(1'b1, 32'h2, 1'b1);
    cycle(1'b1, 32'h3, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    check("pre_rst_count", 32'(zb.count), 32'd3);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_pushZo", 32'(zb.pushZo), 32'd0);
    check("async_count", 32'(zb.count), 32'd0);
    check("async_full", 32'(zb.full), 32'd0);
    check("async_ovf", 32'(zb.ovf), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b1, 32'h11, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    check("first_pushZo", 32'(zb.pushZo), 32'd1);
    check("first_Zo", zb.Zo, 32'h11);
    cycle(1'b0, 32'h0, 1'b0);

    // pass-through, one cycle latency
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, W'(i), 1'b0);
      if (i > 1) begin
        check("pass_Zo", zb.Zo, 32'(i - 1));
        check("pass_count", 32'(zb.count), 32'd1);
      end
    end
    cycle(1'b0, 32'h0, 1'b0);
    check("pass_last", zb.Zo, 32'd20);
    cycle(1'b0, 32'h0, 1'b0);
    check("pass_empty", 32'(zb.pushZo), 32'd0);

    // fill and stall, then overflow
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 32'hA0 + 32'(i), 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    check("fill_count", 32'(zb.count), 32'd8);
    check("fill_full", 32'(zb.full), 32'd1);
    check("fill_head", zb.Zo, 32'hA0);
    cycle(1'b1, 32'hDEAD, 1'b1);
    check("stall_head", zb.Zo, 32'hA0);
    cycle(1'b0, 32'h0, 1'b1);
    check("ovf_set", 32'(zb.ovf), 32'd1);
    check("ovf_count", 32'(zb.count), 32'd8);
    for (int k = 0; k < DEPTH; k++) begin
      cycle(1'b0, 32'h0, 1'b0);
      check("drain_Zo", zb.Zo, 32'hA0 + 32'(k));
    end
    cycle(1'b0, 32'h0, 1'b1);
    check("drain_count", 32'(zb.count), 32'd0);
    check("ovf_sticky", 32'(zb.ovf), 32'd1);

    // full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 32'hB0 + 32'(i), 1'b1);
    cycle(1'b1, 32'hBEEF, 1'b0);
    check("sim_full", 32'(zb.full), 32'd1);
    for (int k = 1; k <= DEPTH; k++) begin
      cycle(1'b0, 32'h0, 1'b0);
      if (k == 1) begin
        check("sim_count", 32'(zb.count), 32'd8);
        check("sim_ovf", 32'(zb.ovf), 32'd0);
      end
      check("sim_Zo", zb.Zo, (k < DEPTH) ? 32'hB0 + 32'(k) : 32'hBEEF);
    end
    cycle(1'b0, 32'h0, 1'b0);
    check("sim_empty", 32'(zb.count), 32'd0);

    // random traffic, model-checked every cycle
    do_reset();
    for (int i = 0; i < 1000; i++)
      cycle(logic'($urandom_range(1, 100) <= 50), W'($urandom), logic'($urandom_range(1, 100) <= 30));
    cycle(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++)
      cycle(1'b0, 32'h0, 1'b0);
    check("final_count", 32'(zb.count), 32'd0);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/calc_zbuf.md
# calc_zbuf

Output elastic buffer placed directly downstream of the calc pipeline. Calc drives `Z`/`pushZ` with no backpressure, so this block accepts every pushed result unconditionally into a DEPTH-entry FIFO. It then re-presents the results to the next consumer on a push/stop handshake. Overflow is detected and latched, never silently hidden.

## Interface
- `W`, 32: data width; matches calc `Z`.
- `DEPTH`, 8: FIFO entries; power of 2, ≥2.
- `CW`, $clog2(DEPTH+1): width of `count`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserting low clears all state immediately; deassertion synchronous to `clk` by system).
- `Z`  in  W  result from calc.
- `pushZ`  in  1  `Z` valid this cycle; no stop returned to calc.
- `Zo`  out  W  head-of-FIFO data.
- `pushZo`  out  1  `Zo` valid (FIFO non-empty).
- `stopZo`  in  1  consumer stall; transfer occurs on edge where `pushZo && !stopZo`.
- `count`  out  CW  current occupancy, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `ovf`  out  1  sticky: a push was dropped since reset.

## Operation
- Storage: DEPTH×W register array, write pointer `wp`, read pointer `rp` (log2(DEPTH) bits each, wrap modulo DEPTH), occupancy counter `count`.
- Pop = `pushZo && !stopZo`. On pop: `rp <= rp+1`.
- Write = `pushZ && (!full || pop)`. On write: `mem[wp] <= Z`, `wp <= wp+1`.
- Drop = `pushZ && full && !pop`. Data discarded, `wp`/`count` unchanged, `ovf <= 1`.
- `count` next: +1 on write without pop, −1 on pop without write, unchanged on both or neither.
- `Zo = mem[rp]` (combinational read of registered array); `pushZo = (count != 0)`; `full` decoded from `count`. No combinational path from `pushZ`/`Z`/`stopZo` to any output.
- Order preserved strictly FIFO; no bypass from `Z` to `Zo`.
- `Zo` must stay stable while `pushZo && stopZo` (head entry not overwritten: writes never target `rp` slot while occupied).
- `ovf` cleared only by reset.
- Reset (async, `rst` low): `wp=0`, `rp=0`, `count=0`, `ovf=0`. Hence `pushZo=0`, `full=0`, and `Zo` holds `mem[0]`. Memory contents are not reset; `Zo` is don't-care while `pushZo=0`, and the bench must not check it. Reset mid-stream discards all held entries. The first push after release is stored at entry 0.

## Timing
- Latency: `pushZ` at edge N → `pushZo=1`, `Zo=Z` after edge N (visible cycle N+1) when FIFO was empty.
- Throughput: one write and one pop per cycle sustained; empty FIFO with continuous push and `stopZo=0` holds `count` at 1.
- Full + push + pop same edge: both occur, `count` stays DEPTH, no `ovf`.
- Empty + pop impossible (`pushZo=0`); `stopZo` ignored when empty.
- `count` and `full` update on the same edge as the pointer movement.
- Wrap: pointers roll DEPTH−1 → 0 with no bubble.

## Test plan
- Reset: drive `rst=0` mid-cycle with FIFO holding 3 entries → `pushZo`, `count`, `full`, `ovf` go 0 immediately without a clock edge. After release, push `Z=32'h11` → `pushZo=1`, `Zo=32'h11` one cycle later.
- Pass-through: `stopZo=0`, push 1,2,3,…,20 on consecutive cycles → `Zo` sequence 1..20, each appearing one cycle after its push, `count` ≤1, `ovf=0`.
- Fill and stall: `stopZo=1`, push 8 values `32'hA0..A7` → `count=8`, `full=1`, `Zo=32'hA0` stable. Release `stopZo` → A0..A7 drain in order, `count` reaches 0.
- Overflow: with full FIFO and `stopZo=1`, push `32'hDEAD` → dropped, `ovf=1`, `count=8`. Drain → `32'hDEAD` never appears, and `ovf` stays 1.
- Full simultaneous: full FIFO, `stopZo=0`, push `32'hBEEF` same cycle → `count` stays 8, `ovf=0`, `32'hBEEF` emerges 8th after the current head.
- Wrap/random: 1000 cycles of random `pushZ` (50%) and `stopZo` (30%) → output matches reference queue model; `count` equals model occupancy every cycle; `ovf` set iff model drops.
